// File: rtl/apb4_archinfo_ext_pkg.sv
// Shared address map, CTRL/STAT bit positions and helpers for the APB4 arch-info block.
package apb4_archinfo_ext_pkg;

  localparam logic [7:0] ADDR_CTRL     = 8'h00;
  localparam logic [7:0] ADDR_SYS      = 8'h04;
  localparam logic [7:0] ADDR_UPT_LO   = 8'h08;
  localparam logic [7:0] ADDR_UPT_HI   = 8'h0C;
  localparam logic [7:0] ADDR_STAT     = 8'h10;
  localparam logic [7:0] ADDR_ID_BASE  = 8'h20;
  localparam logic [7:0] ADDR_SCR_BASE = 8'h40;

  localparam int CTRL_LOCK_BIT   = 0;
  localparam int CTRL_CNT_EN_BIT = 1;
  localparam int CTRL_CLR_BIT    = 2;
  localparam int STAT_LOCK_BIT   = 0;
  localparam int STAT_SHV_BIT    = 1;

  localparam int NUM_ID_MAX  = 8;
  localparam int NUM_SCR_MAX = 8;

  typedef enum logic [2:0] {
    SEL_CTRL,
    SEL_SYS,
    SEL_UPT_LO,
    SEL_UPT_HI,
    SEL_STAT,
    SEL_ID,
    SEL_SCR,
    SEL_NONE
  } reg_sel_e;

  // Word-index decode; ID and SCR windows are 8 words each, trimmed to the populated count.
  function automatic reg_sel_e sel_decode(input logic [5:0] widx,
                                          input logic [3:0] nid,
                                          input logic [3:0] nscr);
    reg_sel_e sel;
    sel = SEL_NONE;
    if (widx == ADDR_CTRL[7:2])        sel = SEL_CTRL;
    else if (widx == ADDR_SYS[7:2])    sel = SEL_SYS;
    else if (widx == ADDR_UPT_LO[7:2]) sel = SEL_UPT_LO;
    else if (widx == ADDR_UPT_HI[7:2]) sel = SEL_UPT_HI;
    else if (widx == ADDR_STAT[7:2])   sel = SEL_STAT;
    else if (widx[5:3] == ADDR_ID_BASE[7:5] && {1'b0, widx[2:0]} < nid)
      sel = SEL_ID;
    else if (widx[5:3] == ADDR_SCR_BASE[7:5] && {1'b0, widx[2:0]} < nscr)
      sel = SEL_SCR;
    return sel;
  endfunction

  function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++)
      if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
    return res;
  endfunction

endpackage

// File: rtl/archinfo_uptime.sv
// Prescaled 64-bit uptime counter with a high-word shadow for coherent LO-then-HI reads.
module archinfo_uptime #(
  parameter int CLK_DIV = 100
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_en,
  input  logic        i_clr,
  input  logic        i_lo_rd,
  input  logic        i_hi_rd,
  output logic [31:0] o_upt_lo,
  output logic [31:0] o_shadow,
  output logic        o_shadow_vld
);

  localparam logic [15:0] LP_LAST = 16'(CLK_DIV - 1);

  logic [15:0] r_presc;
  logic [63:0] r_upt;
  logic [31:0] r_shadow;
  logic        r_shv;
  logic        w_tick;

  assign w_tick = i_en && (r_presc == LP_LAST);

  // Clear takes priority over a coincident tick.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_presc <= '0;
      r_upt   <= '0;
    end else if (i_clr) begin
      r_presc <= '0;
      r_upt   <= '0;
    end else if (i_en) begin
      r_presc <= w_tick ? 16'd0 : r_presc + 16'd1;
      if (w_tick) r_upt <= r_upt + 64'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shadow <= '0;
      r_shv    <= 1'b0;
    end else begin
      if (i_lo_rd) r_shadow <= r_upt[63:32];
      if (i_clr)        r_shv <= 1'b0;
      else if (i_lo_rd) r_shv <= 1'b1;
      else if (i_hi_rd) r_shv <= 1'b0;
    end
  end

  assign o_upt_lo     = r_upt[31:0];
  assign o_shadow     = r_shadow;
  assign o_shadow_vld = r_shv;

endmodule

// File: rtl/apb4_archinfo_ext.sv
// APB4 zero-wait-state architecture info block: CTRL/SYS/uptime/STAT/ID/scratch registers.
// Uptime counter logic is built only when ARCHINFO_UPTIME_EN is defined.
module apb4_archinfo_ext
  import apb4_archinfo_ext_pkg::*;
#(
  parameter int          NUM_ID   = 4,
  parameter int          NUM_SCR  = 2,
  parameter int          CLK_DIV  = 100,
  parameter logic [31:0] SYS_INFO = 32'h0000_0000,
  parameter logic [31:0] ID_VAL [NUM_ID] = '{default: 32'h0}
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [7:0]  paddr_i,
  input  logic        psel_i,
  input  logic        penable_i,
  input  logic        pwrite_i,
  input  logic [31:0] pwdata_i,
  input  logic [3:0]  pstrb_i,
  output logic [31:0] prdata_o,
  output logic        pready_o,
  output logic        pslverr_o
);

  localparam logic [3:0] LP_NID  = 4'((NUM_ID  > NUM_ID_MAX)  ? NUM_ID_MAX  : NUM_ID);
  localparam logic [3:0] LP_NSCR = 4'((NUM_SCR > NUM_SCR_MAX) ? NUM_SCR_MAX : NUM_SCR);

  logic        w_acc, w_wr, w_rd;
  logic [2:0]  w_sub;
  reg_sel_e    w_sel;
  logic        w_ctrl_wr, w_scr_wr;
  logic        w_cnt_en;
  logic [31:0] w_upt_lo, w_upt_hi;
  logic        w_shv;
  logic [31:0] w_rdata;
  logic        w_err;
  logic        w_unused_addr;

  logic        r_lock;
  logic [31:0] r_scr [NUM_SCR];

  assign w_acc         = psel_i & penable_i;
  assign w_wr          = w_acc & pwrite_i;
  assign w_rd          = w_acc & ~pwrite_i;
  assign w_sub         = paddr_i[4:2];
  assign w_sel         = sel_decode(paddr_i[7:2], LP_NID, LP_NSCR);
  assign w_unused_addr = ^paddr_i[1:0];

  // Once locked, CTRL and scratch writes are refused (LOCK itself is already sticky).
  assign w_ctrl_wr = w_wr && (w_sel == SEL_CTRL) && !r_lock;
  assign w_scr_wr  = w_wr && (w_sel == SEL_SCR)  && !r_lock;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                                  r_lock <= 1'b0;
    else if (w_ctrl_wr && pwdata_i[CTRL_LOCK_BIT]) r_lock <= 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int j = 0; j < NUM_SCR; j++) r_scr[j] <= '0;
    end else begin
      for (int j = 0; j < NUM_SCR; j++)
        if (w_scr_wr && w_sub == 3'(j))
          r_scr[j] <= strb_merge(r_scr[j], pwdata_i, pstrb_i);
    end
  end

`ifdef ARCHINFO_UPTIME_EN
  logic r_cnt_en;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)       r_cnt_en <= 1'b1;
    else if (w_ctrl_wr) r_cnt_en <= pwdata_i[CTRL_CNT_EN_BIT];
  end

  archinfo_uptime #(
    .CLK_DIV (CLK_DIV)
  ) u_uptime (
    .i_clk        (clk_i),
    .i_rst_n      (rst_n_i),
    .i_en         (r_cnt_en),
    .i_clr        (w_ctrl_wr & pwdata_i[CTRL_CLR_BIT]),
    .i_lo_rd      (w_rd && (w_sel == SEL_UPT_LO)),
    .i_hi_rd      (w_rd && (w_sel == SEL_UPT_HI)),
    .o_upt_lo     (w_upt_lo),
    .o_shadow     (w_upt_hi),
    .o_shadow_vld (w_shv)
  );

  assign w_cnt_en = r_cnt_en;
`else
  localparam int LP_UNUSED_CLK_DIV = CLK_DIV;

  assign w_cnt_en = 1'b0;
  assign w_upt_lo = '0;
  assign w_upt_hi = '0;
  assign w_shv    = 1'b0;
`endif

  always_comb begin
    w_rdata = '0;
    w_err   = 1'b0;
    case (w_sel)
      SEL_CTRL: begin
        w_rdata[CTRL_LOCK_BIT]   = r_lock;
        w_rdata[CTRL_CNT_EN_BIT] = w_cnt_en;
        w_err                    = pwrite_i & r_lock;
      end
      SEL_SYS: begin
        w_rdata = SYS_INFO;
        w_err   = pwrite_i;
      end
      SEL_UPT_LO: begin
        w_rdata = w_upt_lo;
        w_err   = pwrite_i;
      end
      SEL_UPT_HI: begin
        w_rdata = w_upt_hi;
        w_err   = pwrite_i;
      end
      SEL_STAT: begin
        w_rdata[STAT_LOCK_BIT] = r_lock;
        w_rdata[STAT_SHV_BIT]  = w_shv;
        w_err                  = pwrite_i;
      end
      SEL_ID: begin
        for (int i = 0; i < NUM_ID; i++)
          if (w_sub == 3'(i)) w_rdata = ID_VAL[i];
        w_err = pwrite_i;
      end
      SEL_SCR: begin
        for (int j = 0; j < NUM_SCR; j++)
          if (w_sub == 3'(j)) w_rdata = r_scr[j];
        w_err = pwrite_i & r_lock;
      end
      default: w_err = 1'b1;
    endcase
  end

  // Outputs are quiet outside a read access phase and while reset is held.
  assign prdata_o  = (w_rd && rst_n_i) ? w_rdata : 32'h0;
  assign pslverr_o = w_acc & rst_n_i & w_err;
  assign pready_o  = 1'b1;

endmodule

// File: tb/tb_apb4_archinfo_ext.sv
// Self-checking bench for apb4_archinfo_ext (covers both ARCHINFO_UPTIME_EN builds).
module tb_apb4_archinfo_ext;

  localparam int          NID  = 4;
  localparam int          NSCR = 2;
  localparam int          DIV  = 4;
  localparam logic [31:0] SYS  = 32'h1234_5678;
  localparam logic [31:0] IDV [NID] = '{32'hA000_0001, 32'hB000_0002,
                                        32'hC000_0003, 32'hD000_0004};
`ifdef ARCHINFO_UPTIME_EN
  localparam bit UPT = 1'b1;
`else
  localparam bit UPT = 1'b0;
`endif
  localparam logic [31:0] CTRL_RST = UPT ? 32'h2 : 32'h0;

  logic        clk, rst_n;
  logic [7:0]  paddr;
  logic        psel, penable, pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata;
  logic        pready, pslverr;

  apb4_archinfo_ext #(
    .NUM_ID   (NID),
    .NUM_SCR  (NSCR),
    .CLK_DIV  (DIV),
    .SYS_INFO (SYS),
    .ID_VAL   (IDV)
  ) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .paddr_i   (paddr),
    .psel_i    (psel),
    .penable_i (penable),
    .pwrite_i  (pwrite),
    .pwdata_i  (pwdata),
    .pstrb_i   (pstrb),
    .prdata_o  (prdata),
    .pready_o  (pready),
    .pslverr_o (pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference model: register file state plus a count of enabled clock edges since clear.
  bit              m_lock, m_en, m_sv;
  logic [31:0]     m_scr [NSCR];
  logic [31:0]     m_shadow;
  longint unsigned m_cyc;

  function automatic logic [63:0] m_upt();
    return UPT ? (m_cyc / 64'(DIV)) : 64'd0;
  endfunction

  task automatic model_step();
    bit          clr, en_old;
    int          w;
    logic [63:0] u;
    if (!rst_n) begin
      m_lock = 1'b0; m_en = UPT; m_sv = 1'b0; m_shadow = '0; m_cyc = 0;
      for (int j = 0; j < NSCR; j++) m_scr[j] = '0;
      return;
    end
    clr = 1'b0; en_old = m_en; w = int'(paddr[7:2]); u = m_upt();
    if (psel && penable) begin
      if (pwrite) begin
        if (w == 0 && !m_lock) begin
          if (pwdata[0]) m_lock = 1'b1;
          if (UPT) begin m_en = pwdata[1]; clr = pwdata[2]; end
        end else if (w >= 16 && w < 16 + NSCR && !m_lock) begin
          for (int b = 0; b < 4; b++)
            if (pstrb[b]) m_scr[w-16][8*b +: 8] = pwdata[8*b +: 8];
        end
      end else if (UPT) begin
        if (w == 2) begin m_shadow = u[63:32]; m_sv = 1'b1; end
        else if (w == 3) m_sv = 1'b0;
      end
    end
    if (clr) begin m_cyc = 0; m_sv = 1'b0; end
    else if (en_old) m_cyc++;
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  task automatic model_read(input logic [7:0] a, input bit wr,
                            output logic [31:0] d, output bit e);
    int w;
    logic [63:0] u;
    w = int'(a[7:2]); u = m_upt(); d = '0; e = 1'b0;
    if (w == 0)      begin d[0] = m_lock; d[1] = m_en & UPT; e = wr & m_lock; end
    else if (w == 1) begin d = SYS; e = wr; end
    else if (w == 2) begin d = u[31:0]; e = wr; end
    else if (w == 3) begin d = m_shadow; e = wr; end
    else if (w == 4) begin d[0] = m_lock; d[1] = m_sv; e = wr; end
    else if (w >= 8 && w < 8 + NID)    begin d = IDV[w-8]; e = wr; end
    else if (w >= 16 && w < 16 + NSCR) begin d = m_scr[w-16]; e = wr & m_lock; end
    else e = 1'b1;
    if (wr) d = '0;
  endtask

  task automatic xfer(input bit wr, input logic [7:0] a, input logic [31:0] wd,
                      input logic [3:0] st, output logic [31:0] rd, output logic er,
                      output logic [31:0] ed, output bit ee);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd; pstrb = st;
    @(negedge clk);
    penable = 1'b1;
    #1;
    rd = prdata; er = pslverr;
    model_read(a, wr, ed, ee);
    @(posedge clk);
    #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic xchk(input string nm, input bit wr, input logic [7:0] a,
                      input logic [31:0] wd, input logic [3:0] st,
                      output logic [31:0] rd, output logic er);
    logic [31:0] ed;
    bit          ee;
    xfer(wr, a, wd, st, rd, er, ed, ee);
    chk({nm, "_data"}, rd, ed);
    chk({nm, "_err"}, {31'b0, er}, {31'b0, ee});
  endtask

  typedef struct {
    bit          wr;
    logic [7:0]  a;
    logic [31:0] wd;
    logic [3:0]  st;
    logic [31:0] ed;
    bit          ee;
  } vec_t;

  function automatic vec_t mk(bit wr, logic [7:0] a, logic [31:0] wd, logic [3:0] st,
                              logic [31:0] ed, bit ee);
    vec_t v;
    v.wr = wr; v.a = a; v.wd = wd; v.st = st; v.ed = ed; v.ee = ee;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl [$];
    logic [31:0] rd, ed, lo, hi;
    logic        er;
    bit          ee, ok, saw_wrap;
    logic [7:0]  addrs [19];

    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;

    tbl.push_back(mk(0, 8'h00, 0, 0, CTRL_RST, 0));
    tbl.push_back(mk(0, 8'h04, 0, 0, SYS, 0));
    tbl.push_back(mk(0, 8'h20, 0, 0, IDV[0], 0));
    tbl.push_back(mk(0, 8'h24, 0, 0, IDV[1], 0));
    tbl.push_back(mk(0, 8'h28, 0, 0, IDV[2], 0));
    tbl.push_back(mk(0, 8'h2C, 0, 0, IDV[3], 0));
    tbl.push_back(mk(0, 8'h40, 0, 0, 32'h0, 0));
    tbl.push_back(mk(0, 8'h44, 0, 0, 32'h0, 0));
    tbl.push_back(mk(0, 8'h10, 0, 0, 32'h0, 0));
    tbl.push_back(mk(0, 8'h0C, 0, 0, 32'h0, 0));
    tbl.push_back(mk(1, 8'h04, 32'hFFFF_FFFF, 4'hF, 32'h0, 1));
    tbl.push_back(mk(1, 8'h20, 32'hFFFF_FFFF, 4'hF, 32'h0, 1));
    tbl.push_back(mk(0, 8'h20, 0, 0, IDV[0], 0));
    tbl.push_back(mk(0, 8'h3C, 0, 0, 32'h0, 1));
    tbl.push_back(mk(0, 8'h48, 0, 0, 32'h0, 1));
    tbl.push_back(mk(0, 8'h14, 0, 0, 32'h0, 1));
    tbl.push_back(mk(1, 8'h40, 32'hA5A5_A5A5, 4'b0011, 32'h0, 0));
    tbl.push_back(mk(0, 8'h40, 0, 0, 32'h0000_A5A5, 0));
    tbl.push_back(mk(1, 8'h44, 32'h1234_5678, 4'b0000, 32'h0, 0));
    tbl.push_back(mk(0, 8'h44, 0, 0, 32'h0, 0));
    tbl.push_back(mk(1, 8'h08, 32'h1, 4'hF, 32'h0, 1));
    tbl.push_back(mk(1, 8'h10, 32'h1, 4'hF, 32'h0, 1));
    tbl.push_back(mk(1, 8'h0C, 32'h1, 4'hF, 32'h0, 1));
    tbl.push_back(mk(0, 8'h43, 0, 0, 32'h0000_A5A5, 0));

    addrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h1C, 8'h20, 8'h24, 8'h28,
              8'h2C, 8'h30, 8'h3C, 8'h40, 8'h44, 8'h48, 8'h5C, 8'h60, 8'hFC};

    // Reset state of the outputs
    repeat (3) @(posedge clk);
    #1;
    chk("rst_prdata", prdata, 32'h0);
    chk("rst_pslverr", {31'b0, pslverr}, 32'h0);
    chk("rst_pready", {31'b0, pready}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      logic [31:0] d;
      xfer(tbl[i].wr, tbl[i].a, tbl[i].wd, tbl[i].st, d, er, ed, ee);
      chk($sformatf("vec%0d_data", i), d, tbl[i].ed);
      chk($sformatf("vec%0d_err", i), {31'b0, er}, {31'b0, tbl[i].ee});
    end

    // Reset asserted in the middle of a write access phase
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h40;
    pwdata = 32'hDEAD_BEEF; pstrb = 4'hF;
    @(negedge clk);
    penable = 1'b1;
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    pwrite = 1'b0; paddr = 8'h80;
    #1;
    chk("rstmid_pslverr", {31'b0, pslverr}, 32'h0);
    chk("rstmid_prdata", prdata, 32'h0);
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    xchk("upt_lo_40", 0, 8'h08, 0, 0, lo, er);
    if (UPT) chk("upt_lo_40_range", {31'b0, (lo >= 32'd9 && lo <= 32'd11)}, 32'h1);
    else     chk("upt_lo_40_zero", lo, 32'h0);
    xchk("upt_hi_40", 0, 8'h0C, 0, 0, hi, er);
    chk("upt_hi_40_val", hi, 32'h0);
    chk("upt_hi_40_err", {31'b0, er}, 32'h0);
    xchk("scr0_after_rst", 0, 8'h40, 0, 0, rd, er);
    chk("scr0_after_rst_val", rd, 32'h0);

    // Random traffic against the model; CTRL writes never set LOCK here
    for (int n = 0; n < 300; n++) begin
      logic [7:0]  a;
      logic [31:0] wd;
      bit          wr;
      a  = addrs[$urandom_range(0, 18)] | 8'($urandom_range(0, 3));
      wr = bit'($urandom_range(0, 1));
      wd = $urandom;
      if (a[7:2] == 6'd0) wd[0] = 1'b0;
      xchk($sformatf("rnd%0d_%h", n, a), wr, a, wd, 4'($urandom_range(0, 15)), rd, er);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    // CLR written on the same edge as a prescaler wrap
    xchk("ctrl_en", 1, 8'h00, 32'h2, 4'hF, rd, er);
    repeat (10) @(posedge clk);
    ok = !UPT;
    for (int k = 0; k < 16 && !ok; k++) begin
      @(posedge clk);
      #1;
      if (m_cyc % 64'(DIV) == 64'd2) ok = 1'b1;
    end
    chk("clr_align", {31'b0, ok}, 32'h1);
    xchk("clr_wr", 1, 8'h00, 32'h6, 4'hF, rd, er);
    xchk("clr_lo", 0, 8'h08, 0, 0, lo, er);
    chk("clr_lo_zero", lo, 32'h0);
    chk("clr_lo_noerr", {31'b0, er}, 32'h0);

    // LOCK behaviour
    xchk("lock_set", 1, 8'h00, 32'h3, 4'hF, rd, er);
    xchk("lock_stat", 0, 8'h10, 0, 0, rd, er);
    chk("lock_stat_bit", {31'b0, rd[0]}, 32'h1);
    xchk("lock_scr_wr", 1, 8'h40, 32'hFFFF_FFFF, 4'hF, rd, er);
    chk("lock_scr_wr_err", {31'b0, er}, 32'h1);
    xchk("lock_scr_rd", 0, 8'h40, 0, 0, rd, er);
    xchk("lock_ctrl_wr", 1, 8'h00, 32'h0, 4'hF, rd, er);
    chk("lock_ctrl_wr_err", {31'b0, er}, 32'h1);
    xchk("lock_ctrl_rd", 0, 8'h00, 0, 0, rd, er);

`ifdef ARCHINFO_UPTIME_EN
    // Low-word wrap: every LO/HI pair must come from the same 64-bit sample
    @(negedge clk);
    force dut.u_uptime.r_upt = 64'h0000_0000_FFFF_FFFE;
    @(negedge clk);
    release dut.u_uptime.r_upt;
    saw_wrap = 1'b0;
    for (int p = 0; p < 6; p++) begin
      xfer(0, 8'h08, 0, 0, lo, er, ed, ee);
      xfer(0, 8'h0C, 0, 0, hi, er, ed, ee);
      chk($sformatf("wrap%0d_window", p),
          {31'b0, (lo >= 32'hFFFF_FFF0 || lo < 32'd16)}, 32'h1);
      chk($sformatf("wrap%0d_hi", p), hi, (lo >= 32'h8000_0000) ? 32'h0 : 32'h1);
      chk($sformatf("wrap%0d_hi_err", p), {31'b0, er}, 32'h0);
      if (hi == 32'h1) saw_wrap = 1'b1;
    end
    chk("wrap_seen", {31'b0, saw_wrap}, 32'h1);
`else
    xfer(0, 8'h08, 0, 0, lo, er, ed, ee);
    chk("noupt_lo", lo, 32'h0);
    chk("noupt_lo_err", {31'b0, er}, 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
